// File: rtl/sump_cmd_decoder.sv
// SUMP/ACSP host command decoder: short commands become pulses, long commands are
// assembled into opcode/data pairs, and ID/metadata requests drive a level handshake.
module sump_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  rx_byte_i,
    input  logic        rx_valid_i,
    input  logic        meta_busy_i,
    output logic        begin_meta_transmit_o,
    output logic        send_id_o,
    output logic        cmd_reset_o,
    output logic        cmd_arm_o,
    output logic        long_cmd_valid_o,
    output logic [7:0]  long_cmd_opcode_o,
    output logic [31:0] long_cmd_data_o,
    output logic        cmd_dropped_o,
    output logic        timeout_err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_COLLECT
    } main_state_t;

    typedef enum logic [1:0] {
        M_IDLE,
        M_REQ,
        M_BUSY
    } meta_state_t;

    main_state_t   state_q, state_d;
    meta_state_t   meta_q, meta_d;
    logic [7:0]    opcode_q, opcode_d;
    logic [23:0]   partial_q, partial_d;
    logic [1:0]    count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          begin_q, begin_d;
    logic          send_id_q, send_id_d;
    logic          cmd_reset_q, cmd_reset_d;
    logic          cmd_arm_q, cmd_arm_d;
    logic          long_valid_q, long_valid_d;
    logic [7:0]    long_opcode_q, long_opcode_d;
    logic [31:0]   long_data_q, long_data_d;
    logic          dropped_q, dropped_d;
    logic          timeout_q, timeout_d;

    logic          meta_req;
    logic          meta_req_id;

    always_comb begin
        state_d       = state_q;
        meta_d        = meta_q;
        opcode_d      = opcode_q;
        partial_d     = partial_q;
        count_d       = count_q;
        timer_d       = timer_q;
        begin_d       = begin_q;
        send_id_d     = send_id_q;
        cmd_reset_d   = 1'b0;
        cmd_arm_d     = 1'b0;
        long_valid_d  = 1'b0;
        long_opcode_d = long_opcode_q;
        long_data_d   = long_data_q;
        dropped_d     = 1'b0;
        timeout_d     = 1'b0;
        meta_req      = 1'b0;
        meta_req_id   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid_i) begin
                    if (!rx_byte_i[7]) begin
                        case (rx_byte_i)
                            8'h00: cmd_reset_d = 1'b1;
                            8'h01: cmd_arm_d   = 1'b1;
                            8'h02: begin
                                meta_req    = 1'b1;
                                meta_req_id = 1'b1;
                            end
                            8'h04: meta_req = 1'b1;
                            default: ;
                        endcase
                    end else begin
                        opcode_d = rx_byte_i;
                        count_d  = 2'd0;
                        timer_d  = '0;
                        state_d  = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                // An arriving byte always beats the timeout in the same cycle.
                if (rx_valid_i) begin
                    timer_d = '0;
                    case (count_q)
                        2'd0: partial_d[7:0]   = rx_byte_i;
                        2'd1: partial_d[15:8]  = rx_byte_i;
                        2'd2: partial_d[23:16] = rx_byte_i;
                        default: begin
                            long_opcode_d = opcode_q;
                            long_data_d   = {rx_byte_i, partial_q};
                            long_valid_d  = 1'b1;
                            state_d       = S_IDLE;
                        end
                    endcase
                    count_d = count_q + 2'd1;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    timer_d   = '0;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (meta_q)
            M_IDLE: begin
                if (meta_req) begin
                    send_id_d = meta_req_id;
                    begin_d   = 1'b1;
                    meta_d    = M_REQ;
                end
            end
            M_REQ: begin
                if (meta_busy_i) begin
                    begin_d = 1'b0;
                    meta_d  = M_BUSY;
                end
            end
            M_BUSY: begin
                if (!meta_busy_i) begin
                    meta_d = M_IDLE;
                end
            end
            default: begin
                begin_d = 1'b0;
                meta_d  = M_IDLE;
            end
        endcase

        if (meta_req && (meta_q != M_IDLE)) begin
            dropped_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            meta_q        <= M_IDLE;
            opcode_q      <= '0;
            partial_q     <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            begin_q       <= 1'b0;
            send_id_q     <= 1'b0;
            cmd_reset_q   <= 1'b0;
            cmd_arm_q     <= 1'b0;
            long_valid_q  <= 1'b0;
            long_opcode_q <= '0;
            long_data_q   <= '0;
            dropped_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            meta_q        <= meta_d;
            opcode_q      <= opcode_d;
            partial_q     <= partial_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            begin_q       <= begin_d;
            send_id_q     <= send_id_d;
            cmd_reset_q   <= cmd_reset_d;
            cmd_arm_q     <= cmd_arm_d;
            long_valid_q  <= long_valid_d;
            long_opcode_q <= long_opcode_d;
            long_data_q   <= long_data_d;
            dropped_q     <= dropped_d;
            timeout_q     <= timeout_d;
        end
    end

    assign begin_meta_transmit_o = begin_q;
    assign send_id_o             = send_id_q;
    assign cmd_reset_o           = cmd_reset_q;
    assign cmd_arm_o             = cmd_arm_q;
    assign long_cmd_valid_o      = long_valid_q;
    assign long_cmd_opcode_o     = long_opcode_q;
    assign long_cmd_data_o       = long_data_q;
    assign cmd_dropped_o         = dropped_q;
    assign timeout_err_o         = timeout_q;

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Directed bench for sump_cmd_decoder: a command-level model is compared every cycle,
// and literal expectations pin latencies, data words and pulse totals.
module tb_sump_cmd_decoder;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        meta_busy = 1'b0;
    logic        begin_meta_transmit;
    logic        send_id;
    logic        cmd_reset;
    logic        cmd_arm;
    logic        long_cmd_valid;
    logic [7:0]  long_cmd_opcode;
    logic [31:0] long_cmd_data;
    logic        cmd_dropped;
    logic        timeout_err;

    sump_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .rx_byte_i            (rx_byte),
        .rx_valid_i           (rx_valid),
        .meta_busy_i          (meta_busy),
        .begin_meta_transmit_o(begin_meta_transmit),
        .send_id_o            (send_id),
        .cmd_reset_o          (cmd_reset),
        .cmd_arm_o            (cmd_arm),
        .long_cmd_valid_o     (long_cmd_valid),
        .long_cmd_opcode_o    (long_cmd_opcode),
        .long_cmd_data_o      (long_cmd_data),
        .cmd_dropped_o        (cmd_dropped),
        .timeout_err_o        (timeout_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Command-level model: what the outputs must show after each clock edge.
    bit          m_live = 0;
    bit          m_coll = 0;
    logic [7:0]  m_op = 8'h00;
    logic [7:0]  m_got[$];
    int          m_idle = 0;
    int          m_phase = 0;   // 0 no request, 1 asking, 2 sender busy
    logic        e_reset = 0, e_arm = 0, e_valid = 0, e_drop = 0, e_to = 0;
    logic        e_begin = 0, e_sid = 0;
    logic [7:0]  e_op = 0;
    logic [31:0] e_data = 0;
    int          n_reset = 0, n_arm = 0, n_valid = 0, n_drop = 0, n_to = 0;

    task automatic model_step(input logic rst_n, input logic v, input logic [7:0] b,
                              input logic busy);
        bit req;
        bit id;
        int prev;
        e_reset = 0; e_arm = 0; e_valid = 0; e_drop = 0; e_to = 0;
        req = 0; id = 0;
        if (!rst_n) begin
            m_coll = 0; m_got.delete(); m_idle = 0; m_phase = 0;
            e_begin = 0; e_sid = 0; e_op = 0; e_data = 0;
            return;
        end
        if (!m_coll) begin
            if (v) begin
                if (b < 8'h80) begin
                    if (b == 8'h00) e_reset = 1;
                    else if (b == 8'h01) e_arm = 1;
                    else if (b == 8'h02) begin req = 1; id = 1; end
                    else if (b == 8'h04) req = 1;
                end else begin
                    m_coll = 1; m_op = b; m_got.delete(); m_idle = 0;
                end
            end
        end else if (v) begin
            m_got.push_back(b);
            m_idle = 0;
            if (m_got.size() == 4) begin
                e_op = m_op;
                e_data = {m_got[3], m_got[2], m_got[1], m_got[0]};
                e_valid = 1;
                m_coll = 0;
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                e_to = 1;
                m_coll = 0;
            end
        end
        prev = m_phase;
        if (prev == 0 && req) begin
            m_phase = 1;
            e_sid = id;
        end else if (prev == 1 && busy) begin
            m_phase = 2;
        end else if (prev == 2 && !busy) begin
            m_phase = 0;
        end
        if (req && prev != 0) e_drop = 1;
        e_begin = (m_phase == 1);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step(reset_n, rx_valid, rx_byte, meta_busy);
            m_live = 1;
            @(negedge clock);
            if (m_live) begin
                check("cmd_reset", {31'b0, cmd_reset}, {31'b0, e_reset});
                check("cmd_arm", {31'b0, cmd_arm}, {31'b0, e_arm});
                check("long_cmd_valid", {31'b0, long_cmd_valid}, {31'b0, e_valid});
                check("long_cmd_opcode", {24'b0, long_cmd_opcode}, {24'b0, e_op});
                check("long_cmd_data", long_cmd_data, e_data);
                check("cmd_dropped", {31'b0, cmd_dropped}, {31'b0, e_drop});
                check("timeout_err", {31'b0, timeout_err}, {31'b0, e_to});
                check("begin_meta_transmit", {31'b0, begin_meta_transmit}, {31'b0, e_begin});
                check("send_id", {31'b0, send_id}, {31'b0, e_sid});
            end
            if (cmd_reset === 1'b1) n_reset++;
            if (cmd_arm === 1'b1) n_arm++;
            if (long_cmd_valid === 1'b1) n_valid++;
            if (cmd_dropped === 1'b1) n_drop++;
            if (timeout_err === 1'b1) n_to++;
        end
    end

    logic [7:0] burst[$];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Sends the queued bytes on consecutive cycles; returns 1ns after the last strobe is sampled.
    task automatic send_burst();
        while (burst.size() > 0) begin
            @(posedge clock);
            #1;
            rx_valid = 1'b1;
            rx_byte  = burst.pop_front();
        end
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        burst.push_back(b);
        send_burst();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
        check("reset_flags",
              {25'b0, begin_meta_transmit, send_id, cmd_reset, cmd_arm, long_cmd_valid,
               cmd_dropped, timeout_err}, 32'h0);
        check("reset_opcode", {24'b0, long_cmd_opcode}, 32'h0);
        check("reset_data", long_cmd_data, 32'h0);

        // Short commands with gaps.
        send(8'h00);
        check("reset_pulse_latency", {31'b0, cmd_reset}, 32'h1);
        tick(3);
        send(8'h01);
        check("arm_pulse_latency", {31'b0, cmd_arm}, 32'h1);
        tick(3);

        // ID request, then metadata request, each with a busy window.
        send(8'h02);
        check("id_begin", {31'b0, begin_meta_transmit}, 32'h1);
        check("id_send_id", {31'b0, send_id}, 32'h1);
        tick(3);
        meta_busy = 1'b1;
        check("id_begin_held", {31'b0, begin_meta_transmit}, 32'h1);
        tick(1);
        check("id_begin_dropped", {31'b0, begin_meta_transmit}, 32'h0);
        tick(15);
        meta_busy = 1'b0;
        tick(3);
        send(8'h04);
        check("meta_begin", {31'b0, begin_meta_transmit}, 32'h1);
        check("meta_send_id", {31'b0, send_id}, 32'h0);
        tick(3);
        meta_busy = 1'b1;
        tick(16);
        meta_busy = 1'b0;
        tick(3);

        // Back-to-back long command followed immediately by arm.
        burst = '{8'hC0, 8'h78, 8'h56, 8'h34, 8'h12, 8'h01};
        send_burst();
        check("burst_arm", {31'b0, cmd_arm}, 32'h1);
        check("burst_opcode", {24'b0, long_cmd_opcode}, 32'hC0);
        check("burst_data", long_cmd_data, 32'h12345678);
        tick(3);

        // Partial long command aborted by the idle timeout.
        burst = '{8'h81, 8'hAA};
        send_burst();
        n = 0;
        while (timeout_err !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        check("timeout_latency", n, TO);
        tick(2);
        send(8'h01);
        check("post_timeout_arm", {31'b0, cmd_arm}, 32'h1);
        check("post_timeout_data", long_cmd_data, 32'h12345678);
        check("post_timeout_opcode", {24'b0, long_cmd_opcode}, 32'hC0);
        tick(3);

        // ID request arriving while the sender is still busy is dropped.
        send(8'h04);
        tick(2);
        meta_busy = 1'b1;
        tick(2);
        send(8'h02);
        check("drop_pulse", {31'b0, cmd_dropped}, 32'h1);
        check("drop_send_id", {31'b0, send_id}, 32'h0);
        check("drop_begin", {31'b0, begin_meta_transmit}, 32'h0);
        tick(3);
        meta_busy = 1'b0;
        tick(5);
        check("drop_never_issued", {31'b0, begin_meta_transmit}, 32'h0);

        // Reset mid-command, with a byte offered during reset.
        burst = '{8'h83, 8'h11, 8'h22};
        send_burst();
        @(posedge clock);
        #1;
        reset_n  = 1'b0;
        rx_valid = 1'b1;
        rx_byte  = 8'h01;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(2);
        burst = '{8'h82, 8'h01, 8'h02, 8'h03, 8'h04};
        send_burst();
        check("after_reset_valid", {31'b0, long_cmd_valid}, 32'h1);
        check("after_reset_opcode", {24'b0, long_cmd_opcode}, 32'h82);
        check("after_reset_data", long_cmd_data, 32'h04030201);
        tick(TO + 4);

        check("total_cmd_reset", n_reset, 1);
        check("total_cmd_arm", n_arm, 3);
        check("total_long_valid", n_valid, 2);
        check("total_dropped", n_drop, 1);
        check("total_timeout", n_to, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
